fetch_ctrl: RTL

Instruction-fetch and PC sequencer for the multi-cycle reference CPU. It owns `pc`, `next_pc`, `delayed` and `delayed_pc`, and drives the instruction-bus request/response handshake. It presents one fetched instruction at a time to the decode/execute stages and advances the PC on commit, honouring MIPS branch delay slots. It sits between the core's state machine (fetch, fetch-addr-sent, decode, branch, commit phases) and the instruction bus.

---
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch and PC sequencer: drives the instruction-bus handshake,
// presents one instruction at a time and advances the PC with MIPS delay slots.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        fetch_err,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        in_delay_slot,
    input  logic        commit,
    input  logic        commit_taken,
    input  logic [31:0] commit_target,
    output logic [31:0] retired
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FETCH     = 2'd1;
    localparam logic [1:0] ST_ADDR_SENT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        delayed_q, delayed_d;
    logic [31:0] delayed_pc_q, delayed_pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] retired_q, retired_d;
    logic        pc_aligned;

    assign pc_aligned = (pc_q[1:0] == 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        delayed_d    = delayed_q;
        delayed_pc_d = delayed_pc_q;
        instr_d      = instr_q;
        fetch_err_d  = fetch_err_q;
        retired_d    = retired_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                // A misaligned PC never reaches the bus; it is reported as AdEL-fetch.
                if (!pc_aligned) begin
                    state_d     = ST_DONE;
                    instr_d     = 32'h0;
                    fetch_err_d = 1'b1;
                end else if (iresp_addr_ok) begin
                    if (iresp_data_ok) begin
                        instr_d = iresp_data;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADDR_SENT;
                    end
                end
            end
            ST_ADDR_SENT: begin
                if (iresp_data_ok) begin
                    instr_d = iresp_data;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (commit) begin
                    retired_d   = retired_q + 32'd1;
                    fetch_err_d = 1'b0;
                    state_d     = ST_FETCH;
                    // Branches inside a delay slot are unsupported and dropped.
                    if (delayed_q) begin
                        pc_d      = delayed_pc_q;
                        delayed_d = 1'b0;
                    end else begin
                        pc_d = pc_q + 32'd4;
                        if (commit_taken) begin
                            delayed_d    = 1'b1;
                            delayed_pc_d = commit_target;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            delayed_q    <= 1'b0;
            delayed_pc_q <= 32'h0;
            instr_q      <= 32'h0;
            fetch_err_q  <= 1'b0;
            retired_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            delayed_q    <= delayed_d;
            delayed_pc_q <= delayed_pc_d;
            instr_q      <= instr_d;
            fetch_err_q  <= fetch_err_d;
            retired_q    <= retired_d;
        end
    end

    assign ireq_valid    = (state_q == ST_FETCH) && pc_aligned;
    assign ireq_addr     = pc_q;
    assign instr_valid   = (state_q == ST_DONE);
    assign instr         = instr_q;
    assign fetch_err     = fetch_err_q;
    assign pc            = pc_q;
    assign next_pc       = pc_q + 32'd4;
    assign in_delay_slot = delayed_q;
    assign retired       = retired_q;

endmodule
